i2c_slave_rx: RTL and testbench



---
 rtl/i2c_slave_rx.sv | 150 +++++++++++++++
 tb/tb_i2c_slave_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detection, ACKs address/register/data bytes.
// Optional I2C_SLAVE_AUTOINC_EN: pointer auto-increments for burst writes; otherwise one data byte per transfer.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, ptr;
  logic        ack_on;
`ifndef I2C_SLAVE_AUTOINC_EN
  logic        data_seen;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] byte_nxt;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_nxt  = {shreg[6:0], sda_s};
  assign last_bit  = (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      ptr       <= 8'h00;
      ack_on    <= 1'b0;
`ifndef I2C_SLAVE_AUTOINC_EN
      data_seen <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      // Bus conditions override everything; a partial byte is simply dropped.
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        ack_on <= 1'b0;
      end else if (start_det) begin
        state   <= DEV_ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          DEV_ADDR, REG_ADDR, DATA: begin
            if (scl_rise) begin
              shreg   <= byte_nxt;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (state == DEV_ADDR) begin
                  if (byte_nxt[7:1] == SLAVE_ADDR && !byte_nxt[0]) begin
                    state <= DEV_ACK;
                    busy  <= 1'b1;
                  end else begin
                    state <= IGNORE;
                    busy  <= 1'b0;
                  end
                end else if (state == REG_ADDR) begin
                  ptr   <= byte_nxt;
                  state <= REG_ACK;
`ifndef I2C_SLAVE_AUTOINC_EN
                  data_seen <= 1'b0;
`endif
                end else begin
`ifdef I2C_SLAVE_AUTOINC_EN
                  wr_en   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= byte_nxt;
                  ptr     <= ptr + 8'd1;
                  state   <= DATA_ACK;
`else
                  if (!data_seen) begin
                    wr_en     <= 1'b1;
                    wr_addr   <= ptr;
                    wr_data   <= byte_nxt;
                    data_seen <= 1'b1;
                    state     <= DATA_ACK;
                  end else begin
                    state <= IGNORE;
                    busy  <= 1'b0;
                  end
`endif
                end
              end
            end
          end
          // First SCL fall after bit 8 grabs SDA, the following fall releases it.
          DEV_ACK, REG_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= (state == DEV_ACK) ? REG_ADDR : DATA;
              end
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Randomized bench for i2c_slave_rx: bus-level master, transaction-level reference of ACKs and writes.
module tb_i2c_slave_rx;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int Q = 80;

  logic clk = 1'b0, reset = 1'b1;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic scl_in, sda_in, sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int n_cmp = 0, n_err = 0;
  int oe_hi = 0, oe_bad = 0, wr_dbl = 0;
  logic oe_prev = 1'b0, wr_prev = 1'b0;
  logic [15:0] got_q[$];
  logic [7:0]  tx[$];

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (wr_en && wr_prev) wr_dbl++;
    if (sda_oe) oe_hi++;
    if (!reset && sda_oe !== oe_prev && scl_m) oe_bad++;
    oe_prev = sda_oe;
    wr_prev = wr_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    ack = ~sda_in;
    #Q; scl_m = 1'b0; #Q;
  endtask

  // Reference: address byte decides everything; data byte k lands at reg+k (mod 256).
  task automatic run_txn(input string tag);
    logic ack, exp_ack, addr_ok;
    logic [15:0] exp_q[$];
    got_q.delete();
    oe_hi = 0;
    addr_ok = (tx[0] == 8'hA0);
    i2c_start();
    for (int i = 0; i < tx.size(); i++) begin
      if (i < 2) exp_ack = addr_ok;
      else       exp_ack = addr_ok && (AUTOINC || i == 2);
      if (i >= 2 && exp_ack) exp_q.push_back({8'(int'(tx[1]) + i - 2), tx[i]});
      send_byte(tx[i], ack);
      chk($sformatf("%s_ack%0d", tag, i), {31'd0, ack}, {31'd0, exp_ack});
      if (i == 0) chk($sformatf("%s_busy_on", tag), {31'd0, busy}, {31'd0, addr_ok});
    end
    i2c_stop();
    #100;
    chk($sformatf("%s_nwr", tag), got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), {16'd0, got_q[k]}, {16'd0, exp_q[k]});
    chk($sformatf("%s_busy_off", tag), {31'd0, busy}, 32'd0);
    if (!addr_ok) chk($sformatf("%s_no_oe", tag), oe_hi, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic ack;
    int r, nd;
    #23;
    chk("rst_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    reset = 1'b0;
    #50;

    tx = '{8'hA0, 8'h12, 8'h3C};          run_txn("t1_basic");
    tx = '{8'hA2, 8'h12, 8'h3C};          run_txn("t2_other_addr");
    tx = '{8'hA1, 8'h12};                 run_txn("t3_read");
    tx = '{8'hA0, 8'hFF, 8'h11, 8'h22};   run_txn("t4_wrap");

    // Partial byte cut short by repeated START must not write.
    got_q.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    for (int i = 0; i < 4; i++) bus_bit(1'b1);
    #100;
    chk("t5_partial_nwr", got_q.size(), 32'd0);
    tx = '{8'hA0, 8'h06, 8'h99};          run_txn("t5_restart");

    // Reset during the address ACK.
    i2c_start();
    b = 8'hA0;
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    chk("t6_oe_before", {31'd0, sda_oe}, 32'd1);
    #3 reset = 1'b1;
    #1 chk("t6_oe_async", {31'd0, sda_oe}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    @(negedge clk) reset = 1'b0;
    #100;
    tx = '{8'hA0, 8'h33, 8'h5A};          run_txn("t6_after");

    for (int t = 0; t < 16; t++) begin
      tx.delete();
      r = $urandom_range(0, 3);
      b = 8'($urandom);
      if (r < 2)       tx.push_back(8'hA0);
      else if (r == 2) tx.push_back(8'hA1);
      else             tx.push_back(b);
      tx.push_back(8'($urandom));
      nd = $urandom_range(0, 3);
      for (int i = 0; i < nd; i++) tx.push_back(8'($urandom));
      run_txn($sformatf("rnd%0d", t));
    end

    chk("oe_change_scl_high", oe_bad, 32'd0);
    chk("wr_en_single", wr_dbl, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
